// File: rtl/tt_um_asiclab_adder_bist.sv
// rtl/tt_um_asiclab_adder_bist.sv - operand sweep generator and latency-aligned checker for the nibble adder tile (option macro: ADDER_BIST_STOP_ON_FAIL_EN)
module tt_um_asiclab_adder_bist #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // DRAIN lasts exactly LAT cycles so the last issued operand reaches the pipeline head
  localparam logic [1:0] DRAIN_LAST = 2'(LAT - 1);

  state_t     state;
  state_t     state_nx;
  logic       start_q;
  logic       start_pulse;
  logic       launch;
  logic [7:0] counter;
  logic [1:0] drain_cnt;
  logic [3:0] exp_now;
  logic       pipe_v [LAT];
  logic [3:0] pipe_e [LAT];
  logic       compare_en;
  logic       mismatch;
  logic       fail_flag;
  logic       fail_nx;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic       fail_q;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  logic [7:0] op_pipe [LAT];
`endif

  // Pins the tile does not use; folded together so they are visibly consumed but never sampled
  wire unused_inputs = &{1'b0, ena, ui_in[7:1], uio_in[7:4]};

  assign start_pulse = ui_in[0] & ~start_q;
  assign exp_now     = counter[7:4] + counter[3:0];
  assign compare_en  = (state == RUN) || (state == DRAIN);
  assign mismatch    = compare_en && pipe_v[LAT-1] && (uio_in[3:0] != pipe_e[LAT-1]);
  assign fail_nx     = fail_flag | mismatch;

  assign uio_out = {busy_q, done_q, pass_q, fail_q, 4'b0000};
  assign uio_oe  = 8'hF0;

  // Next-state logic; a start is only honoured while idle or finished
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_pulse) begin
          state_nx = RUN;
          launch   = 1'b1;
        end
      end
      RUN: begin
        if (counter == 8'hFF) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_nx = DONE;
    end
`endif
  end

  // State register and start-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= ui_in[0];
    end
  end

  // Operand counter, operand output, drain counter and sticky fail flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter   <= 8'h00;
      uo_out    <= 8'h00;
      drain_cnt <= 2'd0;
      fail_flag <= 1'b0;
    end else begin
      if (launch) begin
        counter   <= 8'h00;
        drain_cnt <= 2'd0;
        fail_flag <= 1'b0;
      end else begin
        fail_flag <= fail_nx;
        if (state == RUN) begin
          uo_out    <= counter;
          counter   <= counter + 8'd1;
          drain_cnt <= 2'd0;
        end
        if (state == DRAIN) begin
          drain_cnt <= drain_cnt + 2'd1;
        end
      end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
      // Freeze the operand that produced the first bad sum
      if (mismatch) begin
        uo_out <= op_pipe[LAT-1];
      end
`endif
    end
  end

  // Expected-sum pipeline; only RUN inserts valid entries, so DRAIN flushes with bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 4'h0;
      end
    end else if (launch) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 4'h0;
      end
    end else begin
      pipe_v[0] <= (state == RUN);
      pipe_e[0] <= (state == RUN) ? exp_now : 4'h0;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
    end
  end

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  // Operand shadow pipeline kept in step with the expected-sum pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        op_pipe[i] <= 8'h00;
      end
    end else begin
      op_pipe[0] <= counter;
      for (int i = 1; i < LAT; i++) begin
        op_pipe[i] <= op_pipe[i-1];
      end
    end
  end
`endif

  // Registered status pins, derived from the state being entered so done and verdict rise together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      busy_q <= (state_nx == RUN) || (state_nx == DRAIN);
      done_q <= (state_nx == DONE);
      pass_q <= (state_nx == DONE) && !fail_nx;
      fail_q <= (state_nx == DONE) && fail_nx;
    end
  end

endmodule

// File: tb/tb_tt_um_asiclab_adder_bist.sv
// tb/tb_tt_um_asiclab_adder_bist.sv - directed scoreboard bench for the adder BIST with LAT=1 and LAT=3 instances
module tb_tt_um_asiclab_adder_bist;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  localparam logic [7:0] FAULT_UO   = 8'h3A;
  localparam int         FAULT_BUSY = 60;
`else
  localparam logic [7:0] FAULT_UO   = 8'hFF;
  localparam int         FAULT_BUSY = 257;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out3;
  logic [7:0] uio_in3;
  logic [7:0] uio_out3;
  logic [7:0] uio_oe3;

  int n_assert = 0;
  int n_fail   = 0;
  int mode     = 0;
  logic [7:0] exp_q [$];

  logic [3:0] sum1;
  logic [3:0] d1, d2;
  logic [3:0] e1, e2;

  tt_um_asiclab_adder_bist #(.LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_asiclab_adder_bist #(.LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out3),
    .uio_in(uio_in3), .uio_out(uio_out3), .uio_oe(uio_oe3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder models: mode 0 correct (latency 1), mode 1 sum forced to 0 at 8'h3A, mode 2 latency-3 correct
  assign sum1 = uo_out[7:4] + uo_out[3:0];
  always_ff @(posedge clk) begin
    d1 <= sum1;
    d2 <= d1;
    e1 <= uo_out3[7:4] + uo_out3[3:0];
    e2 <= e1;
  end
  always_comb begin
    uio_in = 8'hA0;
    if (mode == 2) uio_in[3:0] = d2;
    else if (mode == 1 && uo_out == 8'h3A) uio_in[3:0] = 4'h0;
    else uio_in[3:0] = sum1;
  end
  assign uio_in3 = {4'h5, e2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait3(output int k);
    for (k = 0; k < 20; k++) begin
      if (uio_out3[6]) break;
      tick();
    end
  endtask

  task automatic run_sweep(input int pulse_at, input int reset_at, input bit hold, output int busy_cycles);
    logic [7:0] exp_op;
    exp_q.delete();
    for (int v = 0; v < 256; v++) exp_q.push_back(8'(v));
    ui_in[0] = 1'b1;
    tick();
    if (!hold) ui_in[0] = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 400; c++) begin
      if (!uio_out[7]) break;
      busy_cycles++;
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid_uo", uo_out, 16'h00);
        check("reset_mid_status", uio_out, 16'h00);
        break;
      end
      if (pulse_at >= 0 && c == pulse_at) ui_in[0] = 1'b1;
      if (pulse_at >= 0 && c == pulse_at + 1) ui_in[0] = 1'b0;
      if (c >= 1 && exp_q.size() > 0) begin
        exp_op = exp_q.pop_front();
        check("sweep_operand", uo_out, exp_op);
      end
      tick();
    end
    exp_q.delete();
  endtask

  initial begin
    int bc;
    int k;
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    mode  = 0;
    tick();
    tick();
    check("reset_uo", uo_out, 16'h00);
    check("reset_status", uio_out, 16'h00);
    check("reset_oe", uio_oe, 16'hF0);
    check("reset_uo_lat3", uo_out3, 16'h00);
    check("reset_status_lat3", uio_out3, 16'h00);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_status", uio_out, 16'h00);

    // Clean sweep with correct adders on both instances
    run_sweep(-1, -1, 1'b0, bc);
    check("clean_busy_cycles", 16'(bc), 16'd257);
    check("clean_status", uio_out[7:4], 4'b0110);
    check("clean_uo_final", uo_out, 16'hFF);
    wait3(k);
    check("lat3_extra_drain", 16'(k), 16'd2);
    check("lat3_clean_status", uio_out3[7:4], 4'b0110);

    // Faulty adder at operand 8'h3A
    mode = 1;
    tick();
    run_sweep(-1, -1, 1'b0, bc);
    check("fault_busy_cycles", 16'(bc), 16'(FAULT_BUSY));
    check("fault_status", uio_out[7:4], 4'b0101);
    check("fault_uo", uo_out, 16'(FAULT_UO));
    wait3(k);

    // Latency-3 adder: LAT=1 instance must fail, LAT=3 instance must pass
    mode = 2;
    tick();
    run_sweep(-1, -1, 1'b0, bc);
    check("lat_mismatch_status", uio_out[7:4], 4'b0101);
    wait3(k);
    check("lat3_match_status", uio_out3[7:4], 4'b0110);

    // Start pulse mid-run is ignored
    mode = 0;
    tick();
    run_sweep(50, -1, 1'b0, bc);
    check("midstart_busy_cycles", 16'(bc), 16'd257);
    check("midstart_status", uio_out[7:4], 4'b0110);
    wait3(k);

    // Asynchronous reset at cycle 100, then a clean run
    run_sweep(-1, 100, 1'b0, bc);
    tick();
    tick();
    check("reset_hold_uo", uo_out, 16'h00);
    check("reset_hold_status", uio_out, 16'h00);
    rst_n = 1'b1;
    tick();
    run_sweep(-1, -1, 1'b0, bc);
    check("post_reset_busy_cycles", 16'(bc), 16'd257);
    check("post_reset_status", uio_out[7:4], 4'b0110);
    wait3(k);

    // Start held high: one failing run only, then a fresh edge gives a clean pass
    mode = 1;
    tick();
    run_sweep(-1, -1, 1'b1, bc);
    check("held_status", uio_out[7:4], 4'b0101);
    wait3(k);
    repeat (20) tick();
    check("held_no_rerun_status", uio_out[7:4], 4'b0101);
    check("held_no_rerun_uo", uo_out, 16'(FAULT_UO));
    ui_in[0] = 1'b0;
    mode = 0;
    tick();
    run_sweep(-1, -1, 1'b0, bc);
    check("second_run_busy_cycles", 16'(bc), 16'd257);
    check("second_run_status", uio_out[7:4], 4'b0110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
